// File: rtl/gpio_irq_pkg.sv
// Register map shared by gpio_irq RTL and its firmware driver: bank indices,
// bank count, VERSION and the bytes-per-bank helper.
package gpio_irq_pkg;

  localparam logic [7:0] VERSION = 8'd0;

  localparam int BANK_INPUT     = 0;
  localparam int BANK_OUTPUT    = 1;
  localparam int BANK_DIRECTION = 2;
  localparam int BANK_RISE_EN   = 3;
  localparam int BANK_FALL_EN   = 4;
  localparam int BANK_STATUS    = 5;
  localparam int NUM_BANKS      = 6;

  // Bank n occupies offsets n*B+1 .. n*B+B, MSB byte first; offset 0 is VERSION.
  function automatic int bank_bytes(input int io_width);
    return ((io_width - 1) / 8) + 1;
  endfunction

endpackage

// File: rtl/bus_to_ip.sv
// Basil bus bridge: address window decode, offset generation and the
// read-data drive on the shared bidirectional bus one cycle after a read.
module bus_to_ip #(
  parameter int unsigned BASEADDR  = 0,
  parameter int unsigned HIGHADDR  = 0,
  parameter int          ABUSWIDTH = 16,
  parameter int          DBUSWIDTH = 8
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  inout  wire  [DBUSWIDTH-1:0] BUS_DATA,
  output logic                 IP_RD,
  output logic                 IP_WR,
  output logic [ABUSWIDTH-1:0] IP_ADD,
  output logic [DBUSWIDTH-1:0] IP_DATA_IN,
  input  logic [DBUSWIDTH-1:0] IP_DATA_OUT
);

  localparam int AW1 = ABUSWIDTH + 1;

  logic [ABUSWIDTH:0] w_rel;
  logic               w_cs;
  logic               r_cs_rd;

  // The extra top bit of the subtraction flags addresses below the window.
  assign w_rel      = {1'b0, BUS_ADD} - AW1'(BASEADDR);
  assign w_cs       = !w_rel[ABUSWIDTH] && (w_rel[ABUSWIDTH-1:0] <= ABUSWIDTH'(HIGHADDR - BASEADDR));
  assign IP_ADD     = w_cs ? w_rel[ABUSWIDTH-1:0] : '0;
  assign IP_RD      = w_cs && BUS_RD;
  assign IP_WR      = w_cs && BUS_WR;
  assign IP_DATA_IN = BUS_DATA;

  always_ff @(posedge BUS_CLK) begin
    r_cs_rd <= w_cs && BUS_RD;
  end

  assign BUS_DATA = (r_cs_rd && !BUS_WR) ? IP_DATA_OUT : {DBUSWIDTH{1'bz}};

endmodule

// File: rtl/gpio_edge_capture.sv
// One byte lane of pin capture: input synchroniser, previous-value register
// and sticky write-1-to-clear edge status.
module gpio_edge_capture
  import gpio_irq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit IN_SYNC = 1'b1
) (
  input  logic             BUS_CLK,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_pin,
  input  logic [WIDTH-1:0] i_rise_en,
  input  logic [WIDTH-1:0] i_fall_en,
  input  logic [WIDTH-1:0] i_w1c,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_status
);

  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_status;
  logic [WIDTH-1:0] w_event;

  if (IN_SYNC) begin : g_sync2
    logic [WIDTH-1:0] r_meta;
    // NOTE: non-blocking assignments make r_sync take the old r_meta, giving two real stages.
    always_ff @(posedge BUS_CLK) begin
      if (i_rst) begin
        r_meta <= '0;
        r_sync <= '0;
      end else begin
        r_meta <= i_pin;
        r_sync <= r_meta;
      end
    end
  end else begin : g_sync1
    always_ff @(posedge BUS_CLK) begin
      if (i_rst) r_sync <= '0;
      else       r_sync <= i_pin;
    end
  end

  assign w_event = (r_sync & ~r_prev & i_rise_en) | (~r_sync & r_prev & i_fall_en);

  // The event is OR'd in after the clear so a same-cycle edge survives a W1C.
  always_ff @(posedge BUS_CLK) begin
    if (i_rst) begin
      r_prev   <= '0;
      r_status <= '0;
    end else begin
      r_prev   <= r_sync;
      r_status <= (r_status & ~i_w1c) | w_event;
    end
  end

  assign o_sync   = r_sync;
  assign o_status = r_status;

endmodule

// File: rtl/gpio_irq.sv
// Bus-mapped GPIO with per-bit edge detection, sticky W1C status and a
// registered level IRQ; address decode, config registers and pin drivers live here.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int unsigned          BASEADDR     = 0,
  parameter int unsigned          HIGHADDR     = 0,
  parameter int                   ABUSWIDTH    = 16,
  parameter int                   IO_WIDTH     = 8,
  parameter logic [IO_WIDTH-1:0]  IO_DIRECTION = '0,
  parameter logic [IO_WIDTH-1:0]  IO_TRI       = '0,
  parameter bit                   IN_SYNC      = 1'b1
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  inout  wire  [7:0]           BUS_DATA,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  inout  wire  [IO_WIDTH-1:0]  IO,
  output logic                 IRQ
);

  localparam int B  = bank_bytes(IO_WIDTH);
  localparam int W8 = 8 * B;

  logic                        w_ip_rd;
  logic                        w_ip_wr;
  logic [ABUSWIDTH-1:0]        w_off;
  logic [7:0]                  w_ip_din;
  logic [7:0]                  w_rd_mux;
  logic                        w_rst;
  logic [NUM_BANKS-1:1][B-1:0] w_we;
  logic [W8-1:0]               w_bank_val [NUM_BANKS];
  logic [IO_WIDTH-1:0]         w_sync;
  logic [IO_WIDTH-1:0]         w_status;

  logic [IO_WIDTH-1:0]         r_out;
  logic [IO_WIDTH-1:0]         r_dir;
  logic [IO_WIDTH-1:0]         r_rise_en;
  logic [IO_WIDTH-1:0]         r_fall_en;
  logic [7:0]                  r_rd_data;
  logic                        r_irq;

  bus_to_ip #(
    .BASEADDR  (BASEADDR),
    .HIGHADDR  (HIGHADDR),
    .ABUSWIDTH (ABUSWIDTH),
    .DBUSWIDTH (8)
  ) u_bus (
    .BUS_CLK     (BUS_CLK),
    .BUS_RD      (BUS_RD),
    .BUS_WR      (BUS_WR),
    .BUS_ADD     (BUS_ADD),
    .BUS_DATA    (BUS_DATA),
    .IP_RD       (w_ip_rd),
    .IP_WR       (w_ip_wr),
    .IP_ADD      (w_off),
    .IP_DATA_IN  (w_ip_din),
    .IP_DATA_OUT (r_rd_data)
  );

  // Any write to offset 0 is a soft reset, applied on the same edge as the write.
  assign w_rst = RST || (w_ip_wr && (w_off == '0));

  assign w_bank_val[BANK_INPUT]     = W8'(w_sync);
  assign w_bank_val[BANK_OUTPUT]    = W8'(r_out);
  assign w_bank_val[BANK_DIRECTION] = W8'(r_dir);
  assign w_bank_val[BANK_RISE_EN]   = W8'(r_rise_en);
  assign w_bank_val[BANK_FALL_EN]   = W8'(r_fall_en);
  assign w_bank_val[BANK_STATUS]    = W8'(w_status);

  // Byte k (counted from the LSB) of bank b sits at offset b*B + B - k.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_rd_mux = '0;
    w_we     = '0;
    if (w_off == '0) w_rd_mux = VERSION;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int k = 0; k < B; k++) begin
        if (w_off == ABUSWIDTH'(b * B + B - k)) w_rd_mux = w_bank_val[b][k*8 +: 8];
      end
    end
    for (int b = BANK_OUTPUT; b < NUM_BANKS; b++) begin
      for (int k = 0; k < B; k++) begin
        w_we[b][k] = w_ip_wr && (w_off == ABUSWIDTH'(b * B + B - k));
      end
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (w_rst) begin
      r_out     <= '0;
      r_dir     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else begin
      for (int i = 0; i < IO_WIDTH; i++) begin
        if (w_we[BANK_OUTPUT][i/8])    r_out[i]     <= w_ip_din[i%8];
        if (w_we[BANK_DIRECTION][i/8]) r_dir[i]     <= w_ip_din[i%8];
        if (w_we[BANK_RISE_EN][i/8])   r_rise_en[i] <= w_ip_din[i%8];
        if (w_we[BANK_FALL_EN][i/8])   r_fall_en[i] <= w_ip_din[i%8];
      end
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (w_rst) begin
      r_rd_data <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_ip_rd) r_rd_data <= w_rd_mux;
      r_irq <= |w_status;
    end
  end

  assign IRQ = r_irq;

  for (genvar k = 0; k < B; k++) begin : g_lane
    localparam int WK = (k == B - 1) ? IO_WIDTH - 8 * (B - 1) : 8;
    gpio_edge_capture #(
      .WIDTH   (WK),
      .IN_SYNC (IN_SYNC)
    ) u_cap (
      .BUS_CLK   (BUS_CLK),
      .i_rst     (w_rst),
      .i_pin     (IO[k*8 +: WK]),
      .i_rise_en (r_rise_en[k*8 +: WK]),
      .i_fall_en (r_fall_en[k*8 +: WK]),
      .i_w1c     (w_we[BANK_STATUS][k] ? w_ip_din[WK-1:0] : '0),
      .o_sync    (w_sync[k*8 +: WK]),
      .o_status  (w_status[k*8 +: WK])
    );
  end

  for (genvar i = 0; i < IO_WIDTH; i++) begin : g_pin
    assign IO[i] = (IO_TRI[i] ? r_dir[i] : IO_DIRECTION[i]) ? r_out[i] : 1'bz;
  end

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq at IO_WIDTH=12 (two bytes per bank), all bits tristate,
// two-stage input synchroniser; bus map table plus hand-timed edge/IRQ sequences.
module tb_gpio_irq;

  localparam int          IO_W = 12;
  localparam int unsigned BASE = 32'h0100;

  logic            BUS_CLK = 1'b0;
  logic            RST;
  logic [15:0]     BUS_ADD;
  logic            BUS_RD;
  logic            BUS_WR;
  wire  [7:0]      BUS_DATA;
  wire  [IO_W-1:0] IO;
  logic            IRQ;

  logic            tb_drv;
  logic [7:0]      tb_dat;
  logic [IO_W-1:0] tb_io_en;
  logic [IO_W-1:0] tb_io_val;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         phase;
    bit         wr;
    int         off;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[$];

  assign BUS_DATA = tb_drv ? tb_dat : 8'hzz;
  for (genvar i = 0; i < IO_W; i++) begin : g_pin
    assign IO[i] = tb_io_en[i] ? tb_io_val[i] : 1'bz;
  end

  always #5 BUS_CLK = ~BUS_CLK;

  gpio_irq #(
    .BASEADDR     (BASE),
    .HIGHADDR     (BASE + 15),
    .ABUSWIDTH    (16),
    .IO_WIDTH     (IO_W),
    .IO_DIRECTION (12'h000),
    .IO_TRI       (12'hFFF),
    .IN_SYNC      (1'b1)
  ) dut (
    .BUS_CLK  (BUS_CLK),
    .RST      (RST),
    .BUS_ADD  (BUS_ADD),
    .BUS_DATA (BUS_DATA),
    .BUS_RD   (BUS_RD),
    .BUS_WR   (BUS_WR),
    .IO       (IO),
    .IRQ      (IRQ)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge BUS_CLK);
  endtask

  task automatic bus_write(input int off, input logic [7:0] d);
    BUS_ADD = 16'(BASE + off);
    tb_dat  = d;
    tb_drv  = 1'b1;
    BUS_WR  = 1'b1;
    @(negedge BUS_CLK);
    BUS_WR  = 1'b0;
    tb_drv  = 1'b0;
  endtask

  task automatic bus_read(input int off, output logic [7:0] d);
    BUS_ADD = 16'(BASE + off);
    BUS_RD  = 1'b1;
    @(negedge BUS_CLK);
    BUS_RD  = 1'b0;
    #1;
    d = BUS_DATA;
    @(negedge BUS_CLK);
  endtask

  task automatic read_check(input string name, input int off, input logic [7:0] exp);
    logic [7:0] rd;
    bus_read(off, rd);
    check(name, rd, exp);
  endtask

  task automatic add(input int ph, input bit wr, input int off, input logic [7:0] d);
    vec_t x;
    x.phase = ph;
    x.wr    = wr;
    x.off   = off;
    x.data  = d;
    vecs.push_back(x);
  endtask

  task automatic run_phase(input int ph);
    logic [7:0] rd;
    foreach (vecs[i]) begin
      if (vecs[i].phase == ph) begin
        if (vecs[i].wr) bus_write(vecs[i].off, vecs[i].data);
        else begin
          bus_read(vecs[i].off, rd);
          check($sformatf("p%0d rd off%0d", ph, vecs[i].off), rd, vecs[i].data);
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1; BUS_RD = 1'b0; BUS_WR = 1'b0; BUS_ADD = '0;
    tb_drv = 1'b0; tb_dat = '0; tb_io_en = '0; tb_io_val = '0;

    // Phase 1: reset state, OUTPUT/DIRECTION write with top-nibble masking, loopback INPUT.
    add(1, 0, 0, 8'h00);
    for (int o = 3; o <= 12; o++) add(1, 0, o, 8'h00);
    add(1, 1, 3, 8'hFA); add(1, 1, 4, 8'hA5); add(1, 1, 5, 8'h0F); add(1, 1, 6, 8'hFF);
    add(1, 0, 3, 8'h0A); add(1, 0, 4, 8'hA5); add(1, 0, 5, 8'h0F); add(1, 0, 6, 8'hFF);
    add(1, 0, 1, 8'h0A); add(1, 0, 2, 8'hA5);
    // Phase 2: after soft reset everything is clear; unmapped offsets read 0 and ignore writes.
    add(2, 0, 0, 8'h00);
    for (int o = 3; o <= 12; o++) add(2, 0, o, 8'h00);
    for (int o = 13; o <= 15; o++) add(2, 1, o, 8'hFF);
    for (int o = 13; o <= 15; o++) add(2, 0, o, 8'h00);
    for (int o = 3; o <= 12; o++) add(2, 0, o, 8'h00);
    add(2, 0, 1, 8'h00); add(2, 0, 2, 8'h81);

    repeat (3) @(negedge BUS_CLK);
    RST = 1'b0;
    check("irq after RST", IRQ, 0);

    run_phase(1);
    check("io driven pins", IO, 12'hAA5);

    // Hand pins over to the bench and arm a rising edge on bit 0.
    bus_write(5, 8'h00); bus_write(6, 8'h00);
    tb_io_en = '1; tb_io_val = '0;
    bus_write(8, 8'h01);
    tick(4);

    // Rise on IO[0]: STATUS sets on the 3rd edge, IRQ on the 4th.
    tb_io_val[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge BUS_CLK);
      check($sformatf("irq latency edge%0d", k), IRQ, (k == 4));
    end
    read_check("status lo after rise", 12, 8'h01);
    read_check("status hi after rise", 11, 8'h00);
    tb_io_val[0] = 1'b0;
    tick(5);
    read_check("status lo after fall, no fall_en", 12, 8'h01);
    check("irq held", IRQ, 1);

    // W1C: STATUS clears on the write edge, IRQ follows one cycle later.
    bus_write(12, 8'h01);
    check("irq lags w1c", IRQ, 1);
    tick(1);
    check("irq after w1c", IRQ, 0);
    read_check("status lo after w1c", 12, 8'h00);

    // A rise landing on the same edge as the W1C wins.
    tb_io_val[0] = 1'b1;
    tick(2);
    bus_write(12, 8'h01);
    tick(1);
    check("irq set beats clear", IRQ, 1);
    read_check("status set beats clear", 12, 8'h01);

    // Enabling edges on a static-high pin raises nothing; dropping it gives a fall event.
    bus_write(12, 8'hFF); bus_write(11, 8'hFF);
    tb_io_val[3] = 1'b1;
    tick(5);
    bus_write(8, 8'h09); bus_write(10, 8'h08);
    tick(5);
    read_check("status static pin", 12, 8'h00);
    check("irq static pin", IRQ, 0);
    tb_io_val[3] = 1'b0;
    tick(5);
    read_check("status fall bit3", 12, 8'h08);
    check("irq fall bit3", IRQ, 1);
    bus_write(8, 8'h00); bus_write(10, 8'h00);
    tick(2);
    read_check("status survives enable clear", 12, 8'h08);
    check("irq survives enable clear", IRQ, 1);

    // Build STATUS=0x81 with config registers non-zero, then soft reset.
    bus_write(12, 8'h08);
    bus_write(8, 8'h81);
    tb_io_val[0] = 1'b0;
    tick(5);
    tb_io_val[0] = 1'b1; tb_io_val[7] = 1'b1;
    tick(5);
    read_check("status 0x81", 12, 8'h81);
    check("irq before soft reset", IRQ, 1);
    bus_write(4, 8'h3C); bus_write(10, 8'h40);
    bus_write(0, 8'h5A);
    check("irq after soft reset", IRQ, 0);

    run_phase(2);
    check("irq end", IRQ, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
